complex_operand_loader: RTL and testbench
=========================================

// Module: complex_operand_loader
//
// PURPOSE
//  Upstream feeder for the complex multiplier datapath/control_logic pair.
//  - Accepts a narrow word stream (a_re, a_im, b_re, b_im) and assembles each 4-word set.
//  - Presents each set in parallel to the multiplier with an op_val/op_rdy handshake.
//  - Double-buffered: the next set is collected while the current one waits for op_rdy.
//
// PARAMETERS
//  DATA_W   8   width of one operand word (real or imaginary part, two's complement)
//  CNT_W    8   width of the completed-set counter (wraps)
//
// PORTS
//  clk        in   1        clock, rising edge
//  rstn       in   1        asynchronous reset, active-low
//  sw_rst     in   1        synchronous soft reset, active-high
//  in_data    in   DATA_W   stream word
//  in_first   in   1        marks word 0 (a_re) of a set
//  in_val     in   1        in_data/in_first valid
//  in_rdy     out  1        loader can accept a word this cycle
//  op_a_re    out  DATA_W   operand A, real part
//  op_a_im    out  DATA_W   operand A, imaginary part
//  op_b_re    out  DATA_W   operand B, real part
//  op_b_im    out  DATA_W   operand B, imaginary part
//  op_val     out  1        operand set valid
//  op_rdy     in   1        multiplier accepts the set (high in its IDLE state)
//  err_frame  out  1        one-cycle pulse on a framing error
//  set_cnt    out  CNT_W    number of sets handed to the multiplier, mod 2^CNT_W
//
// BEHAVIOUR
//  - Reset: rstn low clears everything asynchronously. sw_rst (sync, priority over all else) does the same.
//      - Cleared state: state=COLLECT, word_idx=0, hold_val=0, all op_* = 0.
//      - Cleared outputs: op_val=0, err_frame=0, set_cnt=0, so in_rdy=1.
//  - Word transfer: occurs when in_val & in_rdy. in_rdy = (state==COLLECT), registered-state only, with no combinational path from op_rdy.
//  - Assembly FSM:
//      - COLLECT: word_idx 0..3 selects the assembly register (0 a_re, 1 a_im, 2 b_re, 3 b_im).
//      - On the word_idx=3 transfer, the set completes:
//          - If hold_val=0, or hold is consumed this cycle (op_val&op_rdy), the set moves to hold.
//            Next cycle: hold_val=1, word_idx=0, stay in COLLECT.
//          - Otherwise go to FULL.
//      - FULL: in_rdy=0. When hold frees (op_val&op_rdy), assembly moves to hold the same edge; go to COLLECT with word_idx=0.
//  - Output handshake:
//      - op_val = hold_val (registered). The op_* outputs are the hold register and stay stable while op_val=1 and op_rdy=0.
//      - A set is consumed on op_val & op_rdy. set_cnt increments by 1 on that edge and wraps from 2^CNT_W-1 to 0.
//  - Latency: 4th-word edge -> op_val=1 in the following cycle, when hold is free. Sustained throughput is 1 word/cycle.
//  - Framing rules (err_frame pulses the cycle after the offending transfer):
//      - in_first=1 while word_idx!=0: the partial set is discarded. The word is stored as a_re and word_idx=1.
//      - in_first=0 while word_idx=0: the word is dropped and word_idx stays 0.
//      - Only in COLLECT; hold contents and op_val are never affected by framing errors.
//  - Simultaneous events: completion and consumption in the same cycle is a pass-through to hold, with no FULL visit.
//    sw_rst wins over every transfer in its cycle.
//  - Reset mid-set: any partial or held set is lost. No op_val is raised for it.
//
// STRUCTURE
//  - Shared package complex_mult_pkg:
//      - DATA_W default.
//      - Word-index constants IDX_A_RE=0, IDX_A_IM=1, IDX_B_RE=2, IDX_B_IM=3.
//      - Loader state encoding COLLECT=0, FULL=1.
//  - Sub-module cplx_operand_slot: 4xDATA_W register bank with a valid flag, load and clear.
//    Instantiated twice, as assembly and hold.
//
// TESTING
//  1. Reset: rstn low, then release.
//     -> in_rdy=1, op_val=0, set_cnt=0, err_frame=0.
//  2. Single set 0x01(first),0x02,0x03,0x04 with op_rdy=1.
//     -> op_val=1 for one cycle with op_a_re=01 a_im=02 b_re=03 b_im=04; set_cnt=1.
//  3. Backpressure: op_rdy=0 and send 3 back-to-back sets (12 words).
//     -> in_rdy=0 after word 8 (FULL).
//     -> Raising op_rdy releases set 1, then 2, then 3 in order, with data intact; set_cnt=3.
//  4. Framing: send 0x11(first),0x12, then 0x21(first),0x22,0x23,0x24.
//     -> err_frame pulses once; delivered set is 21/22/23/24.
//     -> A word with in_first=0 at word_idx=0 is dropped, with an err_frame pulse.
//  5. Pass-through: hold full and op_rdy rising in the cycle of the 4th word.
//     -> No FULL state; the new set is on op_* the next cycle; in_rdy stays 1.
//  6. sw_rst mid-set after 2 words, and again while FULL.
//     -> Next cycle op_val=0, in_rdy=1, set_cnt=0; a following clean set is delivered correctly.
//  7. set_cnt wrap: 256 sets with CNT_W=8 -> set_cnt returns to 0.

Source files
------------

// File: rtl/complex_mult_pkg.sv
// Shared definitions for the complex multiplier front end: default widths,
// operand word order within a set, and the loader FSM encoding.
package complex_mult_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    localparam logic [1:0] IDX_A_RE = 2'd0;
    localparam logic [1:0] IDX_A_IM = 2'd1;
    localparam logic [1:0] IDX_B_RE = 2'd2;
    localparam logic [1:0] IDX_B_IM = 2'd3;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } loader_state_e;

endpackage

// File: rtl/cplx_operand_slot.sv
// Four-word operand register bank with a valid flag. Words are written singly
// (assembly) or all at once (hold); clr wipes data and valid.
module cplx_operand_slot #(
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [1:0]             wr_idx,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   load,
    input  logic [3:0][DATA_W-1:0] load_words,
    input  logic                   mark,
    input  logic                   drop,
    output logic [3:0][DATA_W-1:0] words,
    output logic                   valid
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            words <= '0;
            valid <= 1'b0;
        end else if (clr) begin
            words <= '0;
            valid <= 1'b0;
        end else begin
            if (load)
                words <= load_words;
            else if (wr_en)
                words[wr_idx] <= wr_data;
            // a reload in the same cycle as a drop keeps the slot occupied
            if (load || mark)
                valid <= 1'b1;
            else if (drop)
                valid <= 1'b0;
        end
    end

endmodule

// File: rtl/complex_operand_loader.sv
// Assembles a_re/a_im/b_re/b_im word streams into operand sets and hands them
// to the multiplier through a double buffer (assembly slot + hold slot).
module complex_operand_loader #(
    parameter int DATA_W = complex_mult_pkg::DATA_W,
    parameter int CNT_W  = complex_mult_pkg::CNT_W
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          sw_rst,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_first,
    input  logic                          in_val,
    output logic                          in_rdy,
    output logic [DATA_W-1:0]             op_a_re,
    output logic [DATA_W-1:0]             op_a_im,
    output logic [DATA_W-1:0]             op_b_re,
    output logic [DATA_W-1:0]             op_b_im,
    output logic                          op_val,
    input  logic                          op_rdy,
    output logic                          err_frame,
    output logic [CNT_W-1:0]              set_cnt,
    output complex_mult_pkg::loader_state_e dbg_state
);
    import complex_mult_pkg::*;

    // Handshakes: a word moves on in_val & in_rdy, a set moves on op_val & op_rdy;
    // valids never wait on readys, and in_rdy depends on registered state only.

    loader_state_e           state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q;

    logic                    xfer, consume;
    logic                    asm_wr, asm_mark, asm_drop, asm_val;
    logic [1:0]              asm_wr_idx;
    logic                    hold_load, hold_bypass, hold_val;
    logic [3:0][DATA_W-1:0]  asm_words, hold_words, hold_src;

    assign in_rdy  = (state_q == COLLECT);
    assign xfer    = in_val && in_rdy;
    assign consume = hold_val && op_rdy;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_d       = 1'b0;
        asm_wr      = 1'b0;
        asm_wr_idx  = idx_q;
        asm_mark    = 1'b0;
        asm_drop    = 1'b0;
        hold_load   = 1'b0;
        hold_bypass = 1'b0;
        case (state_q)
            COLLECT: begin
                if (xfer) begin
                    if (in_first) begin
                        // a first word always restarts the set, discarding any partial one
                        asm_wr     = 1'b1;
                        asm_wr_idx = IDX_A_RE;
                        idx_d      = IDX_A_IM;
                        err_d      = (idx_q != IDX_A_RE);
                    end else if (idx_q == IDX_A_RE) begin
                        err_d = 1'b1;
                    end else if (idx_q == IDX_B_IM) begin
                        asm_wr = 1'b1;
                        idx_d  = IDX_A_RE;
                        if (!hold_val || consume) begin
                            hold_load   = 1'b1;
                            hold_bypass = 1'b1;
                        end else begin
                            asm_mark = 1'b1;
                            state_d  = FULL;
                        end
                    end else begin
                        asm_wr = 1'b1;
                        idx_d  = idx_q + 2'd1;
                    end
                end
            end
            FULL: begin
                if (consume && asm_val) begin
                    hold_load = 1'b1;
                    asm_drop  = 1'b1;
                    state_d   = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // On completion the fourth word is not yet in the assembly slot, so it is
    // routed straight into hold alongside the three stored words.
    assign hold_src = hold_bypass ? {in_data, asm_words[2:0]} : asm_words;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= COLLECT;
            idx_q   <= IDX_A_RE;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (sw_rst) begin
            state_q <= COLLECT;
            idx_q   <= IDX_A_RE;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            if (consume)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    cplx_operand_slot #(.DATA_W(DATA_W)) u_asm (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (sw_rst),
        .wr_en      (asm_wr),
        .wr_idx     (asm_wr_idx),
        .wr_data    (in_data),
        .load       (1'b0),
        .load_words ('0),
        .mark       (asm_mark),
        .drop       (asm_drop),
        .words      (asm_words),
        .valid      (asm_val)
    );

    cplx_operand_slot #(.DATA_W(DATA_W)) u_hold (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (sw_rst),
        .wr_en      (1'b0),
        .wr_idx     (2'd0),
        .wr_data    ('0),
        .load       (hold_load),
        .load_words (hold_src),
        .mark       (1'b0),
        .drop       (consume),
        .words      (hold_words),
        .valid      (hold_val)
    );

    assign op_a_re   = hold_words[IDX_A_RE];
    assign op_a_im   = hold_words[IDX_A_IM];
    assign op_b_re   = hold_words[IDX_B_RE];
    assign op_b_im   = hold_words[IDX_B_IM];
    assign op_val    = hold_val;
    assign err_frame = err_q;
    assign set_cnt   = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_complex_operand_loader.sv
// Directed bench for complex_operand_loader: cycle table for single set,
// framing and pass-through, then hand sequences for backpressure, resets and wrap.
module tb_complex_operand_loader;
    import complex_mult_pkg::*;

    logic        clk = 1'b0;
    logic        rstn, sw_rst, in_first, in_val, op_rdy;
    logic [7:0]  in_data;
    logic        in_rdy, op_val, err_frame;
    logic [7:0]  op_a_re, op_a_im, op_b_re, op_b_im, set_cnt;
    loader_state_e dbg_state;
    logic [31:0] ops;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [7:0]  d;
        logic        f, v, r;
        logic        e_rdy, e_val;
        logic [31:0] e_ops;
        logic        e_err;
        logic [7:0]  e_cnt;
    } vec_t;
    vec_t vecs[$];

    complex_operand_loader #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst),
        .in_data(in_data), .in_first(in_first), .in_val(in_val), .in_rdy(in_rdy),
        .op_a_re(op_a_re), .op_a_im(op_a_im), .op_b_re(op_b_re), .op_b_im(op_b_im),
        .op_val(op_val), .op_rdy(op_rdy), .err_frame(err_frame), .set_cnt(set_cnt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign ops = {op_b_im, op_b_re, op_a_im, op_a_re};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic f, input logic v, input logic r);
        in_data  = d;
        in_first = f;
        in_val   = v;
        op_rdy   = r;
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic f, input logic v, input logic r,
                                input logic e_rdy, input logic e_val, input logic [31:0] e_ops,
                                input logic e_err, input logic [7:0] e_cnt);
        vec_t x;
        x.d = d; x.f = f; x.v = v; x.r = r;
        x.e_rdy = e_rdy; x.e_val = e_val; x.e_ops = e_ops; x.e_err = e_err; x.e_cnt = e_cnt;
        return x;
    endfunction

    task automatic send_set(input logic [31:0] words, input logic r);
        for (int w = 0; w < 4; w++) begin
            drive(words[8*w +: 8], (w == 0), 1'b1, r);
            step();
        end
        in_val = 1'b0;
    endtask

    initial begin
        // single set, op_rdy high
        vecs.push_back(mk(8'h01,1,1,1, 1,0,32'h0,        0,8'd0));
        vecs.push_back(mk(8'h02,0,1,1, 1,0,32'h0,        0,8'd0));
        vecs.push_back(mk(8'h03,0,1,1, 1,0,32'h0,        0,8'd0));
        vecs.push_back(mk(8'h04,0,1,1, 1,1,32'h04030201, 0,8'd0));
        vecs.push_back(mk(8'h00,0,0,1, 1,0,32'h04030201, 0,8'd1));
        // framing: restart mid-set, then a stray non-first word
        vecs.push_back(mk(8'h11,1,1,1, 1,0,32'h04030201, 0,8'd1));
        vecs.push_back(mk(8'h12,0,1,1, 1,0,32'h04030201, 0,8'd1));
        vecs.push_back(mk(8'h21,1,1,1, 1,0,32'h04030201, 1,8'd1));
        vecs.push_back(mk(8'h22,0,1,1, 1,0,32'h04030201, 0,8'd1));
        vecs.push_back(mk(8'h23,0,1,1, 1,0,32'h04030201, 0,8'd1));
        vecs.push_back(mk(8'h24,0,1,1, 1,1,32'h24232221, 0,8'd1));
        vecs.push_back(mk(8'h55,0,1,1, 1,0,32'h24232221, 1,8'd2));
        vecs.push_back(mk(8'h00,0,0,1, 1,0,32'h24232221, 0,8'd2));
        vecs.push_back(mk(8'h31,1,1,1, 1,0,32'h24232221, 0,8'd2));
        vecs.push_back(mk(8'h32,0,1,1, 1,0,32'h24232221, 0,8'd2));
        vecs.push_back(mk(8'h33,0,1,1, 1,0,32'h24232221, 0,8'd2));
        vecs.push_back(mk(8'h34,0,1,1, 1,1,32'h34333231, 0,8'd2));
        vecs.push_back(mk(8'h00,0,0,1, 1,0,32'h34333231, 0,8'd3));
        // pass-through: hold busy, op_rdy rises with the 4th word
        vecs.push_back(mk(8'h41,1,1,0, 1,0,32'h34333231, 0,8'd3));
        vecs.push_back(mk(8'h42,0,1,0, 1,0,32'h34333231, 0,8'd3));
        vecs.push_back(mk(8'h43,0,1,0, 1,0,32'h34333231, 0,8'd3));
        vecs.push_back(mk(8'h44,0,1,0, 1,1,32'h44434241, 0,8'd3));
        vecs.push_back(mk(8'h51,1,1,0, 1,1,32'h44434241, 0,8'd3));
        vecs.push_back(mk(8'h52,0,1,0, 1,1,32'h44434241, 0,8'd3));
        vecs.push_back(mk(8'h53,0,1,0, 1,1,32'h44434241, 0,8'd3));
        vecs.push_back(mk(8'h54,0,1,1, 1,1,32'h54535251, 0,8'd4));
        vecs.push_back(mk(8'h00,0,0,1, 1,0,32'h54535251, 0,8'd5));

        // reset
        rstn = 1'b0; sw_rst = 1'b0;
        drive(8'h00, 0, 0, 0);
        step(); step();
        chk("reset in_rdy", in_rdy, 1);
        chk("reset op_val", op_val, 0);
        chk("reset set_cnt", set_cnt, 0);
        chk("reset err_frame", err_frame, 0);
        chk("reset ops", ops, 0);
        rstn = 1'b1;
        step();
        chk("post-reset in_rdy", in_rdy, 1);
        chk("post-reset state", dbg_state, COLLECT);

        foreach (vecs[i]) begin
            drive(vecs[i].d, vecs[i].f, vecs[i].v, vecs[i].r);
            step();
            chk($sformatf("vec%0d in_rdy", i), in_rdy, vecs[i].e_rdy);
            chk($sformatf("vec%0d op_val", i), op_val, vecs[i].e_val);
            chk($sformatf("vec%0d ops", i), ops, vecs[i].e_ops);
            chk($sformatf("vec%0d err_frame", i), err_frame, vecs[i].e_err);
            chk($sformatf("vec%0d set_cnt", i), set_cnt, vecs[i].e_cnt);
        end

        // backpressure: three sets with op_rdy low
        exp_q.push_back(32'h64636261);
        exp_q.push_back(32'h74737271);
        exp_q.push_back(32'h84838281);
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 4; w++) begin
                drive(8'h61 + 8'(16 * k + w), (w == 0), 1'b1, 1'b0);
                step();
                chk($sformatf("bp in_rdy set%0d word%0d", k, w), in_rdy, (k == 1 && w == 3) ? 0 : 1);
            end
        chk("bp state full", dbg_state, FULL);
        drive(8'h81, 1, 1, 0);
        step(); step();
        chk("bp stalled in_rdy", in_rdy, 0);
        chk("bp stalled op_val", op_val, 1);
        chk("bp stalled ops", ops, exp_q[0]);
        chk("bp set1 data", ops, exp_q.pop_front());
        op_rdy = 1'b1;
        step();
        op_rdy = 1'b0;
        chk("bp release cnt", set_cnt, 8'd6);
        chk("bp release op_val", op_val, 1);
        chk("bp release in_rdy", in_rdy, 1);
        chk("bp release state", dbg_state, COLLECT);
        step();
        for (int w = 1; w < 4; w++) begin
            drive(8'h81 + 8'(w), 0, 1, 0);
            step();
        end
        in_val = 1'b0;
        chk("bp refill in_rdy", in_rdy, 0);
        chk("bp set2 data", ops, exp_q.pop_front());
        op_rdy = 1'b1;
        step();
        chk("bp set2 cnt", set_cnt, 8'd7);
        chk("bp set3 data", ops, exp_q.pop_front());
        step();
        chk("bp final cnt", set_cnt, 8'd8);
        chk("bp final op_val", op_val, 0);
        chk("bp queue empty", exp_q.size(), 0);

        // soft reset mid-set, with a word offered in the same cycle
        drive(8'hc1, 1, 1, 1); step();
        drive(8'hc2, 0, 1, 1); step();
        sw_rst = 1'b1; drive(8'hc3, 0, 1, 1); step();
        sw_rst = 1'b0; in_val = 1'b0;
        chk("swrst op_val", op_val, 0);
        chk("swrst in_rdy", in_rdy, 1);
        chk("swrst set_cnt", set_cnt, 0);
        chk("swrst ops", ops, 0);
        drive(8'h91, 1, 1, 1); step();
        chk("swrst restart err", err_frame, 0);
        for (int w = 1; w < 4; w++) begin
            drive(8'h91 + 8'(w), 0, 1, 1);
            step();
        end
        in_val = 1'b0;
        chk("swrst clean set", ops, 32'h94939291);
        chk("swrst clean op_val", op_val, 1);
        step();
        chk("swrst clean cnt", set_cnt, 1);

        // soft reset while FULL
        send_set(32'ha4a3a2a1, 1'b0);
        send_set(32'hb4b3b2b1, 1'b0);
        chk("full before swrst", dbg_state, FULL);
        sw_rst = 1'b1; step(); sw_rst = 1'b0;
        chk("swrst full op_val", op_val, 0);
        chk("swrst full in_rdy", in_rdy, 1);
        chk("swrst full cnt", set_cnt, 0);
        chk("swrst full ops", ops, 0);
        send_set(32'hd4d3d2d1, 1'b1);
        chk("after full swrst set", ops, 32'hd4d3d2d1);
        step();
        chk("after full swrst cnt", set_cnt, 1);
        chk("after full swrst op_val", op_val, 0);

        // asynchronous reset with a held set and a partial one
        send_set(32'hf4f3f2f1, 1'b0);
        drive(8'he1, 1, 1, 0); step();
        drive(8'he2, 0, 1, 0); step();
        in_val = 1'b0;
        chk("pre-async op_val", op_val, 1);
        rstn = 1'b0; #2;
        chk("async op_val", op_val, 0);
        chk("async cnt", set_cnt, 0);
        chk("async in_rdy", in_rdy, 1);
        rstn = 1'b1;
        step();
        chk("post-async op_val", op_val, 0);

        // counter wrap
        for (int s = 0; s < 256; s++) begin
            for (int w = 0; w < 4; w++) begin
                drive(8'(4 * s + w), (w == 0), 1'b1, 1'b1);
                step();
            end
        end
        in_val = 1'b0;
        chk("wrap cnt 255", set_cnt, 8'd255);
        chk("wrap last set", ops, 32'hfffefdfc);
        step();
        chk("wrap cnt 0", set_cnt, 8'd0);
        chk("wrap op_val", op_val, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
